// File: rtl/vga_pkg.sv
// Shared VGA raster definitions: per-axis timing record, the standard 640x480@60 mode,
// and helpers that derive totals, sync window bounds and counter widths.
package vga_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
        logic        pol;
    } vga_timing_t;

    typedef struct packed {
        vga_timing_t h;
        vga_timing_t v;
    } vga_mode_t;

    localparam vga_mode_t VGA_640x480_60 = '{
        h: '{active: 640, fp: 16, sync: 96, bp: 48, pol: 1'b1},
        v: '{active: 480, fp: 10, sync: 2,  bp: 33, pol: 1'b1}
    };

    function automatic int unsigned vga_total(input vga_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    function automatic int unsigned vga_sync_start(input vga_timing_t t);
        return t.active + t.fp;
    endfunction

    function automatic int unsigned vga_sync_end(input vga_timing_t t);
        return t.active + t.fp + t.sync;
    endfunction

    // A single-value range still needs one bit of storage.
    function automatic int unsigned vga_cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Pixel-enable gated shift register that re-times sync/de to match a downstream pipeline.
// DLY=0 collapses to a plain wire.
module vga_sync_delay
    import vga_pkg::*;
#(
    parameter int           W    = 3,
    parameter int           DLY  = 0,
    parameter logic [W-1:0] IDLE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (DLY == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, rst_n, ce, clr};
        assign q = d;
    end else begin : g_shift
        logic [W-1:0] taps [DLY];

        // Clearing fills every tap with the idle pattern so nothing stale leaks out later.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DLY; i++) taps[i] <= IDLE;
            end else if (clr) begin
                for (int i = 0; i < DLY; i++) taps[i] <= IDLE;
            end else if (ce) begin
                taps[0] <= d;
                for (int i = 1; i < DLY; i++) taps[i] <= taps[i-1];
            end
        end

        assign q = taps[DLY-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: h/v counters, registered sync/de/coordinate
// decode, line/frame strobes, and an optional sync/de delay for pipeline alignment.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = int'(VGA_640x480_60.h.active),
    parameter int H_FP     = int'(VGA_640x480_60.h.fp),
    parameter int H_SYNC   = int'(VGA_640x480_60.h.sync),
    parameter int H_BP     = int'(VGA_640x480_60.h.bp),
    parameter int V_ACTIVE = int'(VGA_640x480_60.v.active),
    parameter int V_FP     = int'(VGA_640x480_60.v.fp),
    parameter int V_SYNC   = int'(VGA_640x480_60.v.sync),
    parameter int V_BP     = int'(VGA_640x480_60.v.bp),
    parameter int H_POL    = 1,
    parameter int V_POL    = 1,
    parameter int PIPE_DLY = 0,
    localparam int XW = vga_cnt_width(H_ACTIVE),
    localparam int YW = vga_cnt_width(V_ACTIVE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        PIPE_DLY < 0 || PIPE_DLY > 15) begin : g_bad_params
        $error("vga_timing_gen: timing fields must be >= 1 and PIPE_DLY within 0..15");
    end

    localparam vga_timing_t H_T = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP,
                                    pol: (H_POL != 0)};
    localparam vga_timing_t V_T = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP,
                                    pol: (V_POL != 0)};

    localparam int unsigned H_TOTAL = vga_total(H_T);
    localparam int unsigned V_TOTAL = vga_total(V_T);
    localparam int HW = vga_cnt_width(H_TOTAL);
    localparam int VW = vga_cnt_width(V_TOTAL);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_C = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(vga_sync_start(H_T));
    localparam logic [HW-1:0] HS_END  = HW'(vga_sync_end(H_T));
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(vga_sync_start(V_T));
    localparam logic [VW-1:0] VS_END  = VW'(vga_sync_end(V_T));

    localparam logic [2:0] SYNC_IDLE = {H_T.pol, V_T.pol, 1'b0};

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          de_r;
    logic          hs_r;
    logic          vs_r;
    logic [2:0]    sync_stage;
    logic [2:0]    sync_dly;

    // Raster position; v advances on the same edge that h wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (ce) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        de_r = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        hs_r = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        vs_r = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    end

    // Strobes are re-evaluated every clk so they are one clk wide even with a slow ce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            sync_stage  <= SYNC_IDLE;
        end else if (!en) begin
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            sync_stage  <= SYNC_IDLE;
        end else begin
            line_start  <= ce && (h_cnt == '0);
            frame_start <= ce && (h_cnt == '0) && (v_cnt == '0);
            if (ce) begin
                x          <= de_r ? h_cnt[XW-1:0] : '0;
                y          <= de_r ? v_cnt[YW-1:0] : '0;
                sync_stage <= {hs_r ^ H_T.pol, vs_r ^ V_T.pol, de_r};
            end
        end
    end

    vga_sync_delay #(
        .W    (3),
        .DLY  (PIPE_DLY),
        .IDLE (SYNC_IDLE)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .clr   (~en),
        .d     (sync_stage),
        .q     (sync_dly)
    );

    assign {hsync, vsync, de} = sync_dly;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default mode, a 3-cycle delayed copy, and a tiny
// positive-polarity mode, all sharing clk/rst_n/ce/en.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;
    logic en = 1'b0;

    always #5 clk = ~clk;

    logic       hs0, vs0, de0, ls0, fs0;
    logic [9:0] x0;
    logic [8:0] y0;
    logic       hs3, vs3, de3, ls3, fs3;
    logic [9:0] x3;
    logic [8:0] y3;
    logic       hsT, vsT, deT, lsT, fsT;
    logic [1:0] xT;
    logic [1:0] yT;

    vga_timing_gen dut0 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .en(en),
        .hsync(hs0), .vsync(vs0), .de(de0), .x(x0), .y(y0),
        .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_gen #(.PIPE_DLY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .en(en),
        .hsync(hs3), .vsync(vs3), .de(de3), .x(x3), .y(y3),
        .line_start(ls3), .frame_start(fs3)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(0), .V_POL(0)
    ) dutT (
        .clk(clk), .rst_n(rst_n), .ce(ce), .en(en),
        .hsync(hsT), .vsync(vsT), .de(deT), .x(xT), .y(yT),
        .line_start(lsT), .frame_start(fsT)
    );

    int total  = 0;
    int passed = 0;
    int failed = 0;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int  hs0_lo, de0_hi, vs0_lo, ls0_n, fs0_n, hs3_lo;
        int  hs0_fall, hs3_fall, de3_rise, de0_fall, de3_fall;
        int  hsT_hi, vsT_hi, deT_hi, lsT_n, fsT_n;
        bit  de0_seen, de3_seen;

        // Reset: every output at its idle level.
        tick(3);
        check_output("rst_hsync", hs0, 1);
        check_output("rst_vsync", vs0, 1);
        check_output("rst_de", de0, 0);
        check_output("rst_x", x0, 0);
        check_output("rst_y", y0, 0);
        check_output("rst_line_start", ls0, 0);
        check_output("rst_frame_start", fs0, 0);
        check_output("rst_tiny_hsync", hsT, 0);
        check_output("rst_tiny_vsync", vsT, 0);
        check_output("rst_dly_hsync", hs3, 1);

        // Two full lines at ce=1; sample n reflects counter state n-1.
        rst_n = 1'b1;
        en    = 1'b1;
        ce    = 1'b1;
        hs0_lo = 0; de0_hi = 0; vs0_lo = 0; ls0_n = 0; fs0_n = 0; hs3_lo = 0;
        hs0_fall = 0; hs3_fall = 0; de3_rise = 0; de0_fall = 0; de3_fall = 0;
        hsT_hi = 0; vsT_hi = 0; deT_hi = 0; lsT_n = 0; fsT_n = 0;
        de0_seen = 1'b0; de3_seen = 1'b0;
        for (int n = 1; n <= 1600; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                check_output("first_frame_start", fs0, 1);
                check_output("first_line_start", ls0, 1);
                check_output("first_de", de0, 1);
            end
            if (n == 300) check_output("x_at_h299", x0, 299);
            if (n == 700) check_output("x_in_blank", x0, 0);
            if (n == 801) begin
                check_output("y_line1", y0, 1);
                check_output("x_line1_start", x0, 0);
                check_output("line_start_line1", ls0, 1);
            end
            if (n == 5) check_output("tiny_hs_h4", hsT, 0);
            if (n == 6) check_output("tiny_hs_h5", hsT, 1);
            if (n == 7) check_output("tiny_hs_h6", hsT, 1);
            if (n == 8) check_output("tiny_hs_h7", hsT, 0);
            if (n == 9) check_output("tiny_wrap_line_start", lsT, 1);
            if (!hs0) hs0_lo++;
            if (!hs0 && hs0_fall == 0) hs0_fall = n;
            if (!hs3 && hs3_fall == 0) hs3_fall = n;
            if (!vs0) vs0_lo++;
            if (de0) begin de0_hi++; de0_seen = 1'b1; end
            if (!de0 && de0_seen && de0_fall == 0) de0_fall = n;
            if (de3 && !de3_seen) begin de3_seen = 1'b1; de3_rise = n; end
            if (!de3 && de3_seen && de3_fall == 0) de3_fall = n;
            if (ls0) ls0_n++;
            if (fs0) fs0_n++;
            if (hsT) hsT_hi++;
            if (vsT) vsT_hi++;
            if (deT) deT_hi++;
            if (lsT) lsT_n++;
            if (fsT) fsT_n++;
        end
        check_output("hsync_low_clks_2lines", hs0_lo, 192);
        check_output("de_high_clks_2lines", de0_hi, 1280);
        check_output("vsync_low_clks_2lines", vs0_lo, 0);
        check_output("line_start_count", ls0_n, 2);
        check_output("frame_start_count", fs0_n, 1);
        check_output("hsync_first_fall", hs0_fall, 657);
        check_output("dly_hsync_first_fall", hs3_fall, 660);
        check_output("de_first_fall", de0_fall, 641);
        check_output("dly_de_first_rise", de3_rise, 4);
        check_output("dly_de_first_fall", de3_fall, 644);
        check_output("tiny_hsync_high", hsT_hi, 400);
        check_output("tiny_vsync_high", vsT_hi, 264);
        check_output("tiny_de_high", deT_hi, 404);
        check_output("tiny_line_starts", lsT_n, 200);
        check_output("tiny_frame_starts", fsT_n, 34);

        // Disable mid-active: delay line must flush to idle on the next clk.
        tick(10);
        check_output("dly_de_before_disable", de3, 1);
        en = 1'b0;
        tick(1);
        check_output("dis_de", de0, 0);
        check_output("dis_x", x0, 0);
        check_output("dis_line_start", ls0, 0);
        check_output("dis_dly_de_flushed", de3, 0);
        check_output("dis_dly_hsync", hs3, 1);
        tick(1);

        // Re-enable with ce one clock in four: one line takes 3200 clks.
        hs0_lo = 0; de0_hi = 0; ls0_n = 0; fs0_n = 0; hs3_lo = 0;
        for (int i = 0; i < 3200; i++) begin
            en = 1'b1;
            ce = (i % 4 == 0);
            @(posedge clk);
            #1;
            if (i == 0) begin
                check_output("ce4_frame_start", fs0, 1);
                check_output("ce4_x0", x0, 0);
            end
            if (i == 1) begin
                check_output("ce4_strobe_one_clk", fs0, 0);
                check_output("ce4_x_hold", x0, 0);
                check_output("ce4_de_hold", de0, 1);
            end
            if (i == 1199) check_output("ce4_x_1199", x0, 299);
            if (i == 1200) check_output("ce4_x_1200", x0, 300);
            if (i == 1203) check_output("ce4_x_1203", x0, 300);
            if (!hs0) hs0_lo++;
            if (!hs3) hs3_lo++;
            if (de0) de0_hi++;
            if (ls0) ls0_n++;
            if (fs0) fs0_n++;
        end
        check_output("ce4_hsync_low", hs0_lo, 384);
        check_output("ce4_dly_hsync_low", hs3_lo, 384);
        check_output("ce4_de_high", de0_hi, 2560);
        check_output("ce4_line_start_clks", ls0_n, 1);
        check_output("ce4_frame_start_clks", fs0_n, 1);

        // Async reset mid-line, then restart at the first ce after release.
        ce = 1'b1;
        tick(300);
        check_output("pre_rst_x", x0, 299);
        check_output("pre_rst_y", y0, 1);
        check_output("pre_rst_de", de0, 1);
        rst_n = 1'b0;
        #1;
        check_output("async_rst_de", de0, 0);
        check_output("async_rst_x", x0, 0);
        check_output("async_rst_y", y0, 0);
        check_output("async_rst_hsync", hs0, 1);
        check_output("async_rst_dly_de", de3, 0);
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check_output("post_rst_frame_start", fs0, 1);
        check_output("post_rst_line_start", ls0, 1);
        check_output("post_rst_x", x0, 0);
        check_output("post_rst_de", de0, 1);
        check_output("post_rst_tiny_frame_start", fsT, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
